cmd_decoder: RTL and testbench
==============================

CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, packet start marker.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum idle cycles allowed inside a partial packet.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rdfifo_empty  input  1  high when the ft245 host-to-FPGA read FIFO holds no byte.
REQ-006 SHALL have port rden  output  1  read request to the read FIFO.
REQ-007 SHALL have port rddata  input  8  FIFO byte, valid the cycle after rden is high.
REQ-008 SHALL have port cfg_wr  output  1  one-cycle write strobe for a validated command.
REQ-009 SHALL have port cfg_addr  output  8  register address of the last validated command.
REQ-010 SHALL have port cfg_data  output  16  register data of the last validated command.
REQ-011 SHALL have port err_cnt  output  8  saturating count of checksum failures and timeouts.
REQ-012 SHALL have port busy  output  1  high while a packet is partially received (any state except HUNT).

Function
REQ-013 SHALL frame each packet as 5 bytes: SYNC_BYTE, ADDR, DATA_HI, DATA_LO, CHK; CHK = ADDR ^ DATA_HI ^ DATA_LO.
REQ-014 SHALL drive rden = rst_n && !rdfifo_empty every cycle (back-to-back reads allowed); internal byte_valid = rden registered one cycle.
REQ-015 SHALL implement states HUNT, ADDR, DATA_HI, DATA_LO, CHECK; advance only on byte_valid.
REQ-016 HUNT: byte == SYNC_BYTE -> ADDR; any other byte discarded silently, err_cnt unchanged.
REQ-017 ADDR/DATA_HI/DATA_LO: capture byte, go to next state; a SYNC_BYTE value here is treated as data, not resync.
REQ-018 CHECK: match -> cfg_wr high the cycle after the CHK byte is valid, cfg_addr/cfg_data updated on that same cycle; mismatch -> err_cnt increment, no cfg_wr; both -> HUNT.
REQ-019 cfg_addr and cfg_data SHALL hold their values between strobes; cfg_wr SHALL be high for exactly one cycle per valid packet.
REQ-020 Timeout counter SHALL reset on every byte_valid and count while busy; at TIMEOUT_CYCLES consecutive idle cycles -> HUNT, err_cnt increment, partial bytes dropped.
REQ-021 err_cnt SHALL saturate at 255; simultaneous timeout and checksum error are impossible (exclusive states); a single event increments by exactly 1.
REQ-022 A new packet SHALL be accepted with SYNC_BYTE on the cycle immediately after CHK (zero gap).

Reset
REQ-023 While rst_n low: rden=0, cfg_wr=0, cfg_addr=0, cfg_data=0, err_cnt=0, busy=0, state=HUNT, timeout counter=0, byte_valid=0.
REQ-024 Reset asserted mid-packet SHALL discard the partial packet with no cfg_wr and no err_cnt change; a byte already read before reset is lost.

Structure
REQ-025 SYNC_BYTE default, packet length, and state encodings SHALL live in shared package fmcw_cmd_pkg, also used by the host-side tooling spec.
REQ-026 SHALL be one flat module; no sub-module (checksum and timeout inline).

Verification
REQ-027 FIFO delivers A5 03 12 34 25 -> exactly one cfg_wr pulse, cfg_addr=8'h03, cfg_data=16'h1234, err_cnt=0, 1 cycle after CHK valid.
REQ-028 A5 03 12 34 26 -> no cfg_wr, err_cnt=1, busy low afterward.
REQ-029 00 FF 7E then A5 01 AB CD 67 -> garbage ignored, one cfg_wr with addr 01 data ABCD, err_cnt=0.
REQ-030 A5 03 then rdfifo_empty high for 4096 cycles -> busy low, err_cnt=1; subsequent valid packet decodes normally.
REQ-031 Two valid packets back-to-back with rdfifo_empty never high -> two cfg_wr pulses 5 cycles apart, second values retained.
REQ-032 Reset pulse after A5 03 12, then 34 25 arrives -> no cfg_wr, err_cnt=0, decoder in HUNT; 300 bad-CHK packets -> err_cnt=255.

Source files
------------

// File: rtl/fmcw_cmd_pkg.sv
// Shared definitions for the FMCW command link: framing constants, decoder states
// and the packet checksum. Host-side tooling relies on the same values.
package fmcw_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         PKT_LEN           = 5;
   localparam int         TIMEOUT_DEFAULT   = 4096;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_DATA_HI = 3'd2,
      ST_DATA_LO = 3'd3,
      ST_CHECK   = 3'd4
   } dec_state_t;

   function automatic logic [7:0] pkt_chk(input logic [7:0] addr,
                                          input logic [7:0] data_hi,
                                          input logic [7:0] data_lo);
      return addr ^ data_hi ^ data_lo;
   endfunction

endpackage

// File: rtl/cmd_decoder.sv
// Decodes 5-byte register-write packets from the ft245 read FIFO into a one-cycle
// config write strobe, with checksum validation, idle timeout and an error counter.
module cmd_decoder
   import fmcw_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdfifo_empty,
   output logic        rden,
   input  logic [7:0]  rddata,
   output logic        cfg_wr,
   output logic [7:0]  cfg_addr,
   output logic [15:0] cfg_data,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   dec_state_t      state_reg, state_next;
   logic            byte_valid_reg;
   logic [7:0]      addr_reg, addr_next;
   logic [7:0]      data_hi_reg, data_hi_next;
   logic [7:0]      data_lo_reg, data_lo_next;
   logic [TO_W-1:0] timeout_cnt_reg, timeout_cnt_next;
   logic            cfg_wr_reg, cfg_wr_next;
   logic [7:0]      cfg_addr_reg, cfg_addr_next;
   logic [15:0]     cfg_data_reg, cfg_data_next;
   logic [7:0]      err_cnt_reg, err_cnt_next;
   logic            timeout_hit;
   logic            err_inc;

   // Reads are issued whenever a byte is available; the byte lands one cycle later.
   assign rden     = rst_n && !rdfifo_empty;
   assign cfg_wr   = cfg_wr_reg;
   assign cfg_addr = cfg_addr_reg;
   assign cfg_data = cfg_data_reg;
   assign err_cnt  = err_cnt_reg;
   assign busy     = (state_reg != ST_HUNT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ST_HUNT;
         byte_valid_reg  <= 1'b0;
         addr_reg        <= '0;
         data_hi_reg     <= '0;
         data_lo_reg     <= '0;
         timeout_cnt_reg <= '0;
         cfg_wr_reg      <= 1'b0;
         cfg_addr_reg    <= '0;
         cfg_data_reg    <= '0;
         err_cnt_reg     <= '0;
      end else begin
         state_reg       <= state_next;
         byte_valid_reg  <= rden;
         addr_reg        <= addr_next;
         data_hi_reg     <= data_hi_next;
         data_lo_reg     <= data_lo_next;
         timeout_cnt_reg <= timeout_cnt_next;
         cfg_wr_reg      <= cfg_wr_next;
         cfg_addr_reg    <= cfg_addr_next;
         cfg_data_reg    <= cfg_data_next;
         err_cnt_reg     <= err_cnt_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      addr_next        = addr_reg;
      data_hi_next     = data_hi_reg;
      data_lo_next     = data_lo_reg;
      timeout_cnt_next = '0;
      cfg_wr_next      = 1'b0;
      cfg_addr_next    = cfg_addr_reg;
      cfg_data_next    = cfg_data_reg;
      err_cnt_next     = err_cnt_reg;
      timeout_hit      = 1'b0;
      err_inc          = 1'b0;

      // An arriving byte always restarts the idle window, so it wins over a timeout.
      if (!byte_valid_reg && state_reg != ST_HUNT) begin
         if (timeout_cnt_reg == TO_LAST) begin
            timeout_hit = 1'b1;
         end else begin
            timeout_cnt_next = timeout_cnt_reg + TO_W'(1);
         end
      end

      if (byte_valid_reg) begin
         case (state_reg)
            ST_HUNT: begin
               if (rddata == SYNC_BYTE) begin
                  state_next = ST_ADDR;
               end
            end
            ST_ADDR: begin
               addr_next  = rddata;
               state_next = ST_DATA_HI;
            end
            ST_DATA_HI: begin
               data_hi_next = rddata;
               state_next   = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               data_lo_next = rddata;
               state_next   = ST_CHECK;
            end
            ST_CHECK: begin
               if (rddata == pkt_chk(addr_reg, data_hi_reg, data_lo_reg)) begin
                  cfg_wr_next   = 1'b1;
                  cfg_addr_next = addr_reg;
                  cfg_data_next = {data_hi_reg, data_lo_reg};
               end else begin
                  err_inc = 1'b1;
               end
               state_next = ST_HUNT;
            end
            default: state_next = ST_HUNT;
         endcase
      end

      if (timeout_hit) begin
         state_next = ST_HUNT;
         err_inc    = 1'b1;
      end

      if (err_inc && err_cnt_reg != 8'hFF) begin
         err_cnt_next = err_cnt_reg + 8'd1;
      end
   end

endmodule

// File: tb/tb_cmd_decoder.sv
// Scoreboard bench for cmd_decoder: a FIFO model feeds bytes, a packet-level reference
// model predicts strobes/errors, and a negedge monitor compares every cycle.
module tb_cmd_decoder;
   import fmcw_cmd_pkg::*;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TO   = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdfifo_empty = 1'b1;
   logic [7:0]  rddata = 8'h00;
   logic        rden;
   logic        cfg_wr;
   logic [7:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic [7:0]  err_cnt;
   logic        busy;

   always #5 clk = ~clk;

   cmd_decoder #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rdfifo_empty (rdfifo_empty),
      .rden         (rden),
      .rddata       (rddata),
      .cfg_wr       (cfg_wr),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .err_cnt      (err_cnt),
      .busy         (busy)
   );

   typedef struct {
      int          cyc;
      logic [7:0]  addr;
      logic [15:0] data;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          gap_pct = 0;
   int          strobes = 0;
   int          last_strobe_cyc = 0;
   int          strobe_gap = 0;
   logic [7:0]  fifo_q[$];
   exp_t        exp_q[$];
   logic [7:0]  pkt[$];
   int          idle_m = 0;
   int          err_m = 0;
   logic [7:0]  held_addr = 8'h00;
   logic [15:0] held_data = 16'h0000;
   bit          pend_v = 1'b0;
   logic [7:0]  pend_b = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 50)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Packet-level reference: collect bytes after a sync, judge the frame once complete.
   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      idle_m = 0;
      if (pkt.size() == 0) begin
         if (b == SYNC) pkt.push_back(b);
      end else begin
         pkt.push_back(b);
         if (pkt.size() == PKT_LEN) begin
            if ((pkt[1] ^ pkt[2] ^ pkt[3]) == pkt[4]) begin
               e.cyc  = cyc;
               e.addr = pkt[1];
               e.data = {pkt[2], pkt[3]};
               exp_q.push_back(e);
               held_addr = e.addr;
               held_data = e.data;
            end else if (err_m < 255) begin
               err_m++;
            end
            pkt.delete();
         end
      end
   endtask

   // FIFO model plus reference-model clocking.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            pkt.delete();
            idle_m    = 0;
            err_m     = 0;
            held_addr = 8'h00;
            held_data = 16'h0000;
            pend_v    = 1'b0;
         end else begin
            if (pend_v) begin
               model_byte(pend_b);
            end else if (pkt.size() > 0) begin
               idle_m++;
               if (idle_m >= TO) begin
                  pkt.delete();
                  idle_m = 0;
                  if (err_m < 255) err_m++;
               end
            end
            pend_v = !rdfifo_empty;
            if (pend_v) pend_b = fifo_q.pop_front();
         end
         #1;
         rddata       = pend_v ? pend_b : 8'($urandom);
         rdfifo_empty = (fifo_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
      end
   end

   // Monitor: every cycle compared against the model; strobes popped from the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         check("rden", rden, rst_n && !rdfifo_empty);
         check("busy", busy, pkt.size() > 0);
         check("err_cnt", err_cnt, err_m);
         check("cfg_addr_hold", cfg_addr, held_addr);
         check("cfg_data_hold", cfg_data, held_data);
         if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("cfg_wr_strobe", cfg_wr, 1);
            check("cfg_wr_cycle", cyc, e.cyc);
            if (cfg_wr) begin
               check("strobe_addr", cfg_addr, e.addr);
               check("strobe_data", cfg_data, e.data);
            end
         end else begin
            check("cfg_wr_idle", cfg_wr, 0);
         end
         if (cfg_wr) begin
            strobes++;
            strobe_gap      = cyc - last_strobe_cyc;
            last_strobe_cyc = cyc;
            $display("strobe cyc=%0d addr=%02h data=%04h err_cnt=%0d", cyc, cfg_addr, cfg_data, err_cnt);
         end
      end
   end

   task automatic push_pkt(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                           input logic [7:0] c);
      fifo_q.push_back(SYNC);
      fifo_q.push_back(a);
      fifo_q.push_back(h);
      fifo_q.push_back(l);
      fifo_q.push_back(c);
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while ((fifo_q.size() > 0 || pend_v) && n < max_cycles) begin
         @(posedge clk);
         n++;
      end
      check("drain_bound", n >= max_cycles, 0);
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   initial begin
      int s0;
      logic [7:0] a, h, l, c;

      repeat (3) @(posedge clk);
      #2;
      check("rst_rden", rden, 0);
      check("rst_cfg_wr", cfg_wr, 0);
      check("rst_cfg_addr", cfg_addr, 0);
      check("rst_cfg_data", cfg_data, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single good packet
      s0 = strobes;
      push_pkt(8'h03, 8'h12, 8'h34, 8'h25);
      drain(200);
      check("good_strobes", strobes - s0, 1);
      check("good_addr", cfg_addr, 8'h03);
      check("good_data", cfg_data, 16'h1234);
      check("good_err", err_cnt, 0);

      // Garbage before a good packet
      s0 = strobes;
      fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF); fifo_q.push_back(8'h7E);
      push_pkt(8'h01, 8'hAB, 8'hCD, 8'h67);
      drain(200);
      check("garbage_strobes", strobes - s0, 1);
      check("garbage_addr", cfg_addr, 8'h01);
      check("garbage_data", cfg_data, 16'hABCD);
      check("garbage_err", err_cnt, 0);

      // Bad checksum
      s0 = strobes;
      push_pkt(8'h03, 8'h12, 8'h34, 8'h26);
      drain(200);
      check("badchk_strobes", strobes - s0, 0);
      check("badchk_err", err_cnt, 1);
      check("badchk_busy", busy, 0);
      check("badchk_addr_held", cfg_addr, 8'h01);

      // Partial packet then idle timeout
      fifo_q.push_back(SYNC); fifo_q.push_back(8'h03);
      drain(200);
      repeat (TO - 20) @(posedge clk);
      #2 check("timeout_busy_before", busy, 1);
      repeat (40) @(posedge clk);
      #2 check("timeout_busy_after", busy, 0);
      check("timeout_err", err_cnt, 2);
      s0 = strobes;
      push_pkt(8'h7F, 8'h00, 8'h01, 8'h7E);
      drain(200);
      check("after_timeout_strobes", strobes - s0, 1);
      check("after_timeout_addr", cfg_addr, 8'h7F);
      check("after_timeout_data", cfg_data, 16'h0001);

      // Sync value inside the body is plain data
      push_pkt(SYNC, SYNC, SYNC, SYNC);
      drain(200);
      check("sync_as_data_addr", cfg_addr, 8'hA5);
      check("sync_as_data_data", cfg_data, 16'hA5A5);

      // Back-to-back packets with no gaps
      s0 = strobes;
      push_pkt(8'h10, 8'h20, 8'h30, 8'h00);
      push_pkt(8'h11, 8'h22, 8'h33, 8'h00);
      drain(200);
      check("b2b_strobes", strobes - s0, 2);
      check("b2b_gap", strobe_gap, 5);
      check("b2b_addr", cfg_addr, 8'h11);
      check("b2b_data", cfg_data, 16'h2233);

      // Reset in the middle of a packet
      s0 = strobes;
      fifo_q.push_back(SYNC); fifo_q.push_back(8'h03); fifo_q.push_back(8'h12);
      drain(200);
      check("midpkt_busy", busy, 1);
      reset_pulse();
      fifo_q.push_back(8'h34); fifo_q.push_back(8'h25);
      drain(200);
      check("midrst_strobes", strobes - s0, 0);
      check("midrst_err", err_cnt, 0);
      check("midrst_busy", busy, 0);

      // Error counter saturation
      gap_pct = 25;
      for (int i = 0; i < 300; i++) begin
         a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
         push_pkt(a, h, l, pkt_chk(a, h, l) ^ (8'h01 << $urandom_range(7)));
      end
      drain(20000);
      check("sat_err", err_cnt, 255);

      // Randomized mixed traffic
      reset_pulse();
      gap_pct = 30;
      for (int i = 0; i < 150; i++) begin
         a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
         c = pkt_chk(a, h, l);
         case ($urandom_range(9))
            0, 1:    fifo_q.push_back(8'($urandom));
            2, 3:    push_pkt(a, h, l, c ^ 8'h80);
            default: push_pkt(a, h, l, c);
         endcase
      end
      drain(20000);
      fifo_q.push_back(SYNC); fifo_q.push_back(8'h55); fifo_q.push_back(8'h66);
      drain(200);
      repeat (TO + 10) @(posedge clk);
      #2;
      push_pkt(8'h42, 8'hBE, 8'hEF, pkt_chk(8'h42, 8'hBE, 8'hEF));
      drain(400);
      check("final_addr", cfg_addr, 8'h42);
      check("final_data", cfg_data, 16'hBEEF);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
